// File: rtl/enet_axil_cfg_if.sv
// AXI4-Lite slave-side bundle for the Ethernet MAC configuration bridge.
// master drives requests, slave (the bridge) drives ready/response.
interface enet_axil_cfg_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/enet_axil_cfg.sv
// AXI4-Lite to MAC register-port bridge, one transaction in flight, fair write/read arbitration.
// Optional stall timeout enabled by defining ENET_AXIL_TIMEOUT_EN (limit = TIMEOUT_CYCLES).
module enet_axil_cfg #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    enet_axil_cfg_if.slave        inport,
    output logic [31:0]           cfg_addr_o,
    output logic [31:0]           cfg_data_wr_o,
    output logic                  cfg_stb_o,
    output logic                  cfg_we_o,
    input  logic [31:0]           cfg_data_rd_i,
    input  logic                  cfg_ack_i,
    input  logic                  cfg_stall_i
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        WR_RESP,
        RD_RESP
    } state_t;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] WORD_MASK   = 32'hFFFF_FFFC;

    state_t      state_q, state_d;
    logic        wr_grant_q, wr_grant_d;
    logic        rd_grant_q, rd_grant_d;
    logic        last_rd_q, last_rd_d;
    logic        is_wr_q, is_wr_d;
    logic        bvalid_q, bvalid_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] cfg_addr_q, cfg_addr_d;
    logic [31:0] cfg_data_q, cfg_data_d;
    logic        cfg_stb_q, cfg_stb_d;
    logic        cfg_we_q, cfg_we_d;
    logic        wr_elig;
    logic        rd_elig;

`ifdef ENET_AXIL_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
`endif

    assign wr_elig = inport.awvalid && inport.wvalid;
    assign rd_elig = inport.arvalid;

    always_comb begin
        state_d    = state_q;
        wr_grant_d = wr_grant_q;
        rd_grant_d = rd_grant_q;
        last_rd_d  = last_rd_q;
        is_wr_d    = is_wr_q;
        bvalid_d   = bvalid_q;
        rvalid_d   = rvalid_q;
        bresp_d    = bresp_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        cfg_addr_d = cfg_addr_q;
        cfg_data_d = cfg_data_q;
        cfg_stb_d  = cfg_stb_q;
        cfg_we_d   = cfg_we_q;
`ifdef ENET_AXIL_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                // A set grant flop means the ready pulse is on the bus now: capture the request.
                if (wr_grant_q) begin
                    wr_grant_d = 1'b0;
                    is_wr_d    = 1'b1;
                    cfg_addr_d = inport.awaddr & WORD_MASK;
                    cfg_data_d = inport.wdata;
                    if (inport.wstrb == 4'hF) begin
                        state_d   = REQ;
                        cfg_stb_d = 1'b1;
                        cfg_we_d  = 1'b1;
                    end else begin
                        state_d  = WR_RESP;
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_SLVERR;
                    end
                end else if (rd_grant_q) begin
                    rd_grant_d = 1'b0;
                    is_wr_d    = 1'b0;
                    cfg_addr_d = inport.araddr & WORD_MASK;
                    state_d    = REQ;
                    cfg_stb_d  = 1'b1;
                    cfg_we_d   = 1'b0;
                end else if (wr_elig && (!rd_elig || last_rd_q)) begin
                    wr_grant_d = 1'b1;
                    last_rd_d  = 1'b0;
                end else if (rd_elig) begin
                    rd_grant_d = 1'b1;
                    last_rd_d  = 1'b1;
                end
            end

            REQ: begin
                if (!cfg_stall_i) begin
                    state_d   = WAIT_ACK;
                    cfg_stb_d = 1'b0;
                    cfg_we_d  = 1'b0;
`ifdef ENET_AXIL_TIMEOUT_EN
                    to_cnt_d  = '0;
                end else if (to_cnt_q == CNT_LAST) begin
                    cfg_stb_d = 1'b0;
                    cfg_we_d  = 1'b0;
                    to_cnt_d  = '0;
                    rdata_d   = 32'h0;
                    if (is_wr_q) begin
                        state_d  = WR_RESP;
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_SLVERR;
                    end else begin
                        state_d  = RD_RESP;
                        rvalid_d = 1'b1;
                        rresp_d  = RESP_SLVERR;
                    end
                end else begin
                    to_cnt_d  = to_cnt_q + CNT_W'(1);
`endif
                end
            end

            WAIT_ACK: begin
                if (cfg_ack_i) begin
                    if (is_wr_q) begin
                        state_d  = WR_RESP;
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_OKAY;
                    end else begin
                        state_d  = RD_RESP;
                        rvalid_d = 1'b1;
                        rresp_d  = RESP_OKAY;
                        rdata_d  = cfg_data_rd_i;
                    end
                end
            end

            WR_RESP: begin
                if (inport.bready) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end

            RD_RESP: begin
                if (inport.rready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wr_grant_q <= 1'b0;
            rd_grant_q <= 1'b0;
            last_rd_q  <= 1'b1;
            is_wr_q    <= 1'b0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= 32'h0;
            cfg_addr_q <= 32'h0;
            cfg_data_q <= 32'h0;
            cfg_stb_q  <= 1'b0;
            cfg_we_q   <= 1'b0;
`ifdef ENET_AXIL_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_grant_q <= wr_grant_d;
            rd_grant_q <= rd_grant_d;
            last_rd_q  <= last_rd_d;
            is_wr_q    <= is_wr_d;
            bvalid_q   <= bvalid_d;
            rvalid_q   <= rvalid_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            cfg_addr_q <= cfg_addr_d;
            cfg_data_q <= cfg_data_d;
            cfg_stb_q  <= cfg_stb_d;
            cfg_we_q   <= cfg_we_d;
`ifdef ENET_AXIL_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    assign inport.awready = wr_grant_q;
    assign inport.wready  = wr_grant_q;
    assign inport.arready = rd_grant_q;
    assign inport.bvalid  = bvalid_q;
    assign inport.bresp   = bresp_q;
    assign inport.rvalid  = rvalid_q;
    assign inport.rresp   = rresp_q;
    assign inport.rdata   = rdata_q;
    assign cfg_addr_o     = cfg_addr_q;
    assign cfg_data_wr_o  = cfg_data_q;
    assign cfg_stb_o      = cfg_stb_q;
    assign cfg_we_o       = cfg_we_q;

endmodule

// File: tb/tb_enet_axil_cfg.sv
// Directed bench for enet_axil_cfg: a passive monitor plus a one-cycle ack responder on the MAC side.
module tb_enet_axil_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_addr_o;
    logic [31:0] cfg_data_wr_o;
    logic        cfg_stb_o;
    logic        cfg_we_o;
    logic [31:0] cfg_data_rd_i;
    logic        cfg_ack_i;
    logic        cfg_stall_i;
    logic        spur_ack;

    always #5 clk = ~clk;

    enet_axil_cfg_if ifc ();

    enet_axil_cfg #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .inport        (ifc),
        .cfg_addr_o    (cfg_addr_o),
        .cfg_data_wr_o (cfg_data_wr_o),
        .cfg_stb_o     (cfg_stb_o),
        .cfg_we_o      (cfg_we_o),
        .cfg_data_rd_i (cfg_data_rd_i),
        .cfg_ack_i     (cfg_ack_i),
        .cfg_stall_i   (cfg_stall_i)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Monitor state, written only by the monitor processes below.
    int          cyc = 0;
    int          n_wgrant = 0, n_rgrant = 0, n_b = 0, n_r = 0;
    int          stb_cnt = 0, ack_cnt = 0;
    int          grant_cyc = 0, stb_rise_cyc = 0, b_rise_cyc = 0, r_rise_cyc = 0;
    logic [7:0]  order_bits = 8'h0;
    logic        stb_prev = 1'b0, b_prev = 1'b0, r_prev = 1'b0;
    logic        addr_moved = 1'b0;
    logic [31:0] cap_addr = 32'h0, cap_wd = 32'h0, last_rdata = 32'h0;
    logic        cap_we = 1'b0;
    logic [1:0]  last_bresp = 2'b11, last_rresp = 2'b11;
    logic        ack_next = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifc.awready && ifc.awvalid) begin
            n_wgrant++;
            grant_cyc  = cyc;
            order_bits = {order_bits[6:0], 1'b1};
        end
        if (ifc.arready && ifc.arvalid) begin
            n_rgrant++;
            grant_cyc  = cyc;
            order_bits = {order_bits[6:0], 1'b0};
        end
        if (cfg_stb_o) begin
            if (stb_prev && cfg_addr_o != cap_addr) addr_moved = 1'b1;
            if (!stb_prev) stb_rise_cyc = cyc;
            stb_cnt++;
            cap_addr = cfg_addr_o;
            cap_we   = cfg_we_o;
            cap_wd   = cfg_data_wr_o;
        end
        stb_prev = cfg_stb_o;
        ack_next = cfg_stb_o && !cfg_stall_i;
        if (cfg_ack_i) ack_cnt++;
        if (ifc.bvalid && !b_prev) b_rise_cyc = cyc;
        if (ifc.rvalid && !r_prev) r_rise_cyc = cyc;
        b_prev = ifc.bvalid;
        r_prev = ifc.rvalid;
        if (ifc.bvalid && ifc.bready) begin
            n_b++;
            last_bresp = ifc.bresp;
        end
        if (ifc.rvalid && ifc.rready) begin
            n_r++;
            last_rdata = ifc.rdata;
            last_rresp = ifc.rresp;
        end
    end

    // MAC side acks exactly one cycle after its request is accepted.
    always @(posedge clk) begin
        #1;
        cfg_ack_i = ack_next || spur_ack;
    end

    task automatic issue_write(input string tag, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
        int w0;
        w0 = n_wgrant;
        @(posedge clk); #1;
        ifc.awvalid = 1'b1; ifc.wvalid = 1'b1;
        ifc.awaddr = addr; ifc.wdata = data; ifc.wstrb = strb;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (n_wgrant != w0) break;
        end
        ifc.awvalid = 1'b0; ifc.wvalid = 1'b0;
        check({tag, "_grant"}, 32'(n_wgrant - w0), 32'd1);
    endtask

    task automatic issue_read(input string tag, input logic [31:0] addr);
        int r0;
        r0 = n_rgrant;
        @(posedge clk); #1;
        ifc.arvalid = 1'b1; ifc.araddr = addr;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (n_rgrant != r0) break;
        end
        ifc.arvalid = 1'b0;
        check({tag, "_grant"}, 32'(n_rgrant - r0), 32'd1);
    endtask

    task automatic wait_resp(input int base_b, input int base_r, input int lim);
        for (int i = 0; i < lim; i++) begin
            @(posedge clk); #1;
            if (n_b != base_b || n_r != base_r) break;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    int b0, r0, s0, a0, ws, rs;

    initial begin
        rst = 1'b1;
        ifc.awvalid = 1'b0; ifc.wvalid = 1'b0; ifc.arvalid = 1'b0;
        ifc.awaddr = 32'h0; ifc.wdata = 32'h0; ifc.wstrb = 4'h0; ifc.araddr = 32'h0;
        ifc.bready = 1'b1; ifc.rready = 1'b1;
        cfg_data_rd_i = 32'h0; cfg_stall_i = 1'b0; spur_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {29'b0, ifc.awready, ifc.wready, ifc.arready}, 32'h0);
        check("rst_valid", {30'b0, ifc.bvalid, ifc.rvalid}, 32'h0);
        check("rst_cfg_ctl", {30'b0, cfg_stb_o, cfg_we_o}, 32'h0);
        check("rst_cfg_addr", cfg_addr_o, 32'h0);
        check("rst_cfg_wdata", cfg_data_wr_o, 32'h0);
        check("rst_rdata", ifc.rdata, 32'h0);
        check("rst_resp", {28'b0, ifc.bresp, ifc.rresp}, 32'h0);
        rst = 1'b0;

        // Contested arbitration straight out of reset: both channels keep requesting.
        b0 = n_b; r0 = n_r;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            ws = n_wgrant;
            rs = n_rgrant;
            ifc.awvalid = (ws < 2); ifc.wvalid = (ws < 2);
            ifc.awaddr = 32'h100 + 32'(ws * 4); ifc.wdata = 32'hC0DE_0000 + 32'(ws);
            ifc.wstrb = 4'hF;
            ifc.arvalid = (rs < 2); ifc.araddr = 32'h200 + 32'(rs * 4);
            if (n_b - b0 >= 2 && n_r - r0 >= 2) break;
        end
        ifc.awvalid = 1'b0; ifc.wvalid = 1'b0; ifc.arvalid = 1'b0;
        check("order_wrwr", {24'b0, order_bits}, 32'h0000_000A);
        check("order_bresp_cnt", 32'(n_b - b0), 32'd2);
        check("order_rresp_cnt", 32'(n_r - r0), 32'd2);
        repeat (2) @(posedge clk);
        #1;

        // Plain write, latency from grant.
        b0 = n_b; r0 = n_r;
        issue_write("wr", 32'h0000_1004, 32'hA5A5_0001, 4'hF);
        wait_resp(b0, r0, 40);
        check("wr_cfg_addr", cap_addr, 32'h0000_1004);
        check("wr_cfg_we", {31'b0, cap_we}, 32'd1);
        check("wr_cfg_data", cap_wd, 32'hA5A5_0001);
        check("wr_stb_lat", 32'(stb_rise_cyc - grant_cyc), 32'd1);
        check("wr_bvalid_lat", 32'(b_rise_cyc - grant_cyc), 32'd3);
        check("wr_bresp", {30'b0, last_bresp}, 32'h0);
        check("wr_bresp_cnt", 32'(n_b - b0), 32'd1);

        // Plain read with unaligned address.
        b0 = n_b; r0 = n_r;
        cfg_data_rd_i = 32'h1234_5678;
        issue_read("rd", 32'h0000_1803);
        wait_resp(b0, r0, 40);
        check("rd_cfg_addr", cap_addr, 32'h0000_1800);
        check("rd_cfg_we", {31'b0, cap_we}, 32'd0);
        check("rd_rdata", last_rdata, 32'h1234_5678);
        check("rd_rresp", {30'b0, last_rresp}, 32'h0);
        check("rd_rvalid_lat", 32'(r_rise_cyc - grant_cyc), 32'd3);

        // Five stalled cycles in REQ.
        b0 = n_b; r0 = n_r; s0 = stb_cnt; a0 = ack_cnt;
        cfg_data_rd_i = 32'h0BAD_F00D;
        cfg_stall_i = 1'b1;
        issue_read("stall", 32'h0000_2008);
        for (int i = 0; i < 50; i++) begin
            if (stb_cnt - s0 >= 5) break;
            @(posedge clk); #1;
        end
        cfg_stall_i = 1'b0;
        wait_resp(b0, r0, 40);
        check("stall_stb_cycles", 32'(stb_cnt - s0), 32'd6);
        check("stall_addr_stable", {31'b0, addr_moved}, 32'd0);
        check("stall_cfg_addr", cap_addr, 32'h0000_2008);
        check("stall_ack_cnt", 32'(ack_cnt - a0), 32'd1);
        check("stall_resp_cnt", 32'(n_r - r0), 32'd1);
        check("stall_rdata", last_rdata, 32'h0BAD_F00D);

        // Partial strobe write never reaches the MAC.
        b0 = n_b; r0 = n_r; s0 = stb_cnt;
        issue_write("strb", 32'h0000_3000, 32'h5555_AAAA, 4'h3);
        wait_resp(b0, r0, 40);
        check("strb_no_stb", 32'(stb_cnt - s0), 32'd0);
        check("strb_bresp", {30'b0, last_bresp}, 32'h2);
        check("strb_bresp_cnt", 32'(n_b - b0), 32'd1);

        // Stray ack while idle produces nothing.
        b0 = n_b; r0 = n_r;
        @(posedge clk); #1 spur_ack = 1'b1;
        @(posedge clk); #1 spur_ack = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("spur_ack_resp", 32'((n_b - b0) + (n_r - r0)), 32'd0);

        // Stall that never clears on its own.
        b0 = n_b; r0 = n_r; s0 = stb_cnt;
        cfg_data_rd_i = 32'hDEAD_BEEF;
        cfg_stall_i = 1'b1;
        issue_read("to", 32'h0000_4000);
`ifdef ENET_AXIL_TIMEOUT_EN
        wait_resp(b0, r0, 40);
        cfg_stall_i = 1'b0;
        check("to_stb_cycles", 32'(stb_cnt - s0), 32'd8);
        check("to_rresp", {30'b0, last_rresp}, 32'h2);
        check("to_rdata", last_rdata, 32'h0);
        check("to_resp_cnt", 32'(n_r - r0), 32'd1);
`else
        repeat (20) @(posedge clk);
        #1;
        check("hold_stb_high", {31'b0, cfg_stb_o}, 32'd1);
        check("hold_stb_cycles", 32'(stb_cnt - s0), 32'd20);
        check("hold_no_resp", 32'(n_r - r0), 32'd0);
        cfg_stall_i = 1'b0;
        wait_resp(b0, r0, 40);
        check("hold_rdata", last_rdata, 32'hDEAD_BEEF);
        check("hold_rresp", {30'b0, last_rresp}, 32'h0);
        check("hold_resp_cnt", 32'(n_r - r0), 32'd1);
`endif

        // Reset in the middle of a stalled write drops it.
        cfg_stall_i = 1'b1;
        issue_write("mid", 32'h0000_5000, 32'h1111_2222, 4'hF);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_stb", {31'b0, cfg_stb_o}, 32'd0);
        check("mid_rst_addr", cfg_addr_o, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cfg_stall_i = 1'b0;
        b0 = n_b; r0 = n_r; s0 = stb_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("mid_no_resp", 32'((n_b - b0) + (n_r - r0)), 32'd0);
        check("mid_no_stb", 32'(stb_cnt - s0), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
